stream_demux16: RTL and testbench

//  - Registered 1-to-NUM_OUT stream demultiplexer; the distributing counterpart of the mux16to1/mux4to1 selectors.
//  - Steers one input word, tagged with a channel select, to one of NUM_OUT output channels.
//  - Each output channel has a one-entry holding register and a valid/ready handshake.
//  - Sits between a single producer and up to 16 independent consumers.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_slot.sv | 31 +++
 rtl/stream_demux16.sv | 77 +++++++
 tb/tb_stream_demux16.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package demux_pkg;

  localparam int DEMUX_MAX_OUT = 16;
  localparam int DEMUX_SEL_W   = 4;

  // Bit offset of channel k inside a flattened NUM_OUT*WIDTH bus.
  function automatic int slice_offset(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a valid/ready handshake on its output side.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_out,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             can_load
);

  // The slot can take a new word when it is empty or its current word leaves this cycle.
  assign can_load = !valid | ready_out;

  // A load wins over a drain, so back-to-back words flow at full rate; data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (valid && ready_out) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux16.sv
// Registered 1-to-NUM_OUT stream demultiplexer with per-channel holding registers.
module stream_demux16
  import demux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = DEMUX_MAX_OUT,
  parameter int SEL_W   = DEMUX_SEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     drop_err
);

  logic [NUM_OUT-1:0] can_load;
  logic [NUM_OUT-1:0] load;
  logic               in_range;
  logic               sel_can_load;
  logic               accept;

  // Selects beyond the last channel are legal: they are accepted and thrown away.
  assign in_range = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OUT));

  // Pick the can_load flag of the addressed channel without indexing past NUM_OUT.
  always_comb begin
    sel_can_load = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_sel == SEL_W'(k)) sel_can_load = can_load[k];
    end
  end

  // Ready depends only on the addressed channel, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = in_range ? sel_can_load : 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  // One-hot load vector; an out-of-range select matches no channel.
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = accept & (in_sel == SEL_W'(k));
    end
  end

  // Flag a discarded word for exactly the cycle after it was accepted.
  always_ff @(posedge clk) begin
    if (rst) drop_err <= 1'b0;
    else     drop_err <= accept & !in_range;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    localparam int OFS = slice_offset(k, WIDTH);

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (in_data),
      .ready_out(out_ready[k]),
      .valid    (out_valid[k]),
      .data_out (out_data[OFS +: WIDTH]),
      .can_load (can_load[k])
    );
  end

endmodule

// File: tb/tb_stream_demux16.sv
// Self-checking bench for stream_demux16 with a queue-based reference model.
module tb_stream_demux16;

  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 12;
  localparam int SEL_W   = 4;

  logic                     clk;
  logic                     rst;
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic                     drop_err;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a FIFO of words waiting for its consumer,
  // plus the last word ever delivered to it (what out_data shows when idle).
  logic [WIDTH-1:0] mq [NUM_OUT][$];
  logic [WIDTH-1:0] last_word [NUM_OUT];
  logic             model_drop;

  // Previous cycle's request, used to honour the producer hold rule in random traffic.
  logic             prev_stalled;
  logic [SEL_W-1:0] prev_sel;
  logic [WIDTH-1:0] prev_data;

  stream_demux16 #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_err (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed and expected disagree.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), check in_ready
  // before the rising edge, advance the model, then check all registered outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [SEL_W-1:0] s,
                               input logic [WIDTH-1:0] d, input logic [NUM_OUT-1:0] rdy);
    logic                     exp_ready;
    logic                     acc;
    logic [NUM_OUT-1:0]       ev;
    logic [NUM_OUT*WIDTH-1:0] ed;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rdy;
    #1;
    if (r)                  exp_ready = 1'b0;
    else if (s >= NUM_OUT)  exp_ready = 1'b1;
    else                    exp_ready = (mq[s].size() == 0) || rdy[s];
    checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
    acc = v & exp_ready;
    prev_stalled = v & !exp_ready;
    prev_sel = s;
    prev_data = d;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        mq[k].delete();
        last_word[k] = '0;
      end
      model_drop = 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
      end
      model_drop = acc && (s >= NUM_OUT);
      if (acc && s < NUM_OUT) begin
        mq[s].push_back(d);
        last_word[s] = d;
      end
    end
    #1;
    ev = '0;
    ed = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      ev[k] = (mq[k].size() > 0);
      ed[k*WIDTH +: WIDTH] = ev[k] ? mq[k][0] : last_word[k];
    end
    checkOutput("out_valid", 128'(out_valid), 128'(ev));
    checkOutput("out_data", 128'(out_data), 128'(ed));
    checkOutput("drop_err", 128'(drop_err), 128'(model_drop));
    @(negedge clk);
  endtask

  initial begin
    logic [SEL_W-1:0]   rs;
    logic [WIDTH-1:0]   rd;
    logic               rv;
    logic               rr;
    logic [NUM_OUT-1:0] ro;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_drop = 1'b0;
    prev_stalled = 1'b0; prev_sel = '0; prev_data = '0;
    for (int k = 0; k < NUM_OUT; k++) last_word[k] = '0;
    @(negedge clk);

    // Reset held for two cycles while a word is offered: nothing is captured.
    applyStimulus(1'b1, 1'b1, 4'd1, 8'hFF, '1);
    applyStimulus(1'b1, 1'b1, 4'd1, 8'hFF, '1);
    checkOutput("reset_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_drop", 128'(drop_err), 128'(0));

    // Basic steer to channel 9.
    applyStimulus(1'b0, 1'b1, 4'd9, 8'hA5, '0);
    checkOutput("steer_valid", 128'(out_valid), 128'(12'h200));
    checkOutput("steer_data", 128'(out_data[79:72]), 128'(8'hA5));

    // Back-pressure on channel 3, then redirect to channel 5.
    applyStimulus(1'b0, 1'b1, 4'd3, 8'h11, '0);
    applyStimulus(1'b0, 1'b1, 4'd3, 8'h22, '0);
    checkOutput("bp_hold", 128'(out_data[31:24]), 128'(8'h11));
    applyStimulus(1'b0, 1'b1, 4'd5, 8'h33, '0);
    checkOutput("bp_ch5", 128'(out_data[47:40]), 128'(8'h33));
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, '1);

    // Full rate on channel 0 with all consumers ready.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd0, 8'(i), '1);
      checkOutput("fullrate", 128'(out_data[7:0]), 128'(i));
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, '1);

    // Out-of-range select is accepted and discarded with a one-cycle pulse.
    applyStimulus(1'b0, 1'b1, 4'd13, 8'h3C, '0);
    checkOutput("oor_pulse", 128'(drop_err), 128'(1));
    checkOutput("oor_valid", 128'(out_valid), 128'(0));
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, '0);
    checkOutput("oor_clear", 128'(drop_err), 128'(0));

    // Reset in mid-operation with channels 2 and 7 stalled.
    applyStimulus(1'b0, 1'b1, 4'd2, 8'h44, '0);
    applyStimulus(1'b0, 1'b1, 4'd7, 8'h77, '0);
    applyStimulus(1'b1, 1'b1, 4'd2, 8'h99, '0);
    checkOutput("midrst_valid", 128'(out_valid), 128'(0));
    applyStimulus(1'b0, 1'b1, 4'd2, 8'h5A, '0);
    checkOutput("midrst_reload", 128'(out_valid), 128'(12'h004));

    // Random traffic, respecting the producer hold rule while stalled.
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = 4'($urandom_range(0, 15));
      rd = 8'($urandom);
      ro = NUM_OUT'($urandom);
      rr = ($urandom_range(0, 59) == 0);
      if (prev_stalled && !rr) begin
        rv = 1'b1;
        rs = prev_sel;
        rd = prev_data;
      end
      applyStimulus(rr, rv, rs, rd, ro);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
